// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoder types: opcode/funct3 constants, request op and FSM state enums.
// Used by rv_enc_format and rv_instr_encoder (feature macro RV_ENC_RANGE_CHECK_EN lives there).
package rv_enc_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_LW   = 3'b010;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_ADD  = 3'b000;

    typedef enum logic [1:0] {
        OP_ADDI = 2'b00,
        OP_LW   = 2'b01,
        OP_BNE  = 2'b10,
        OP_ADD  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCEPT,
        S_HOLD,
        S_DONE
    } state_e;

endpackage

// File: rtl/rv_enc_format.sv
// Combinational packing of an encode request into an RV32I word, plus the immediate
// range flag (only meaningful when RV_ENC_RANGE_CHECK_EN is defined, otherwise 0).
module rv_enc_format
    import rv_enc_pkg::*;
(
    input  op_e         op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word,
    output logic        range_bad
);

    always_comb begin
        word = '0;
        unique case (op)
            OP_ADDI: word = {imm[11:0], rs1, F3_ADDI, rd, OPC_OP_IMM};
            OP_LW:   word = {imm[11:0], rs1, F3_LW, rd, OPC_LOAD};
            OP_BNE:  word = {imm[12], imm[10:5], rs2, rs1, F3_BNE, imm[4:1], imm[11], OPC_BRANCH};
            OP_ADD:  word = {7'b0000000, rs2, rs1, F3_ADD, rd, OPC_OP};
        endcase
    end

`ifdef RV_ENC_RANGE_CHECK_EN
    // A 13-bit signed value fits 12 bits iff its top two bits agree; any even
    // 13-bit value is already inside the branch range, so only oddness fails.
    always_comb begin
        range_bad = 1'b0;
        unique case (op)
            OP_ADDI, OP_LW: range_bad = (imm[12] != imm[11]);
            OP_BNE:         range_bad = imm[0];
            OP_ADD:         range_bad = 1'b0;
        endcase
    end
`else
    logic unused_imm0;
    assign unused_imm0 = imm[0];
    assign range_bad   = 1'b0;
`endif

endmodule

// File: rtl/rv_instr_encoder.sv
// RV32I instruction encoder that streams encoded words into an instruction memory.
// Define RV_ENC_RANGE_CHECK_EN to reject out-of-range immediates and raise sticky err.
module rv_instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [4:0]            req_rd,
    input  logic [4:0]            req_rs1,
    input  logic [4:0]            req_rs2,
    input  logic [12:0]           req_imm,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_ready,
    output logic                  done,
    output logic                  err
);

    state_e      state;
    logic [31:0] enc_word;
    logic        range_bad;
    logic        reject;
    logic        last_word;

    rv_enc_format u_format (
        .op        (op_e'(req_op)),
        .rd        (req_rd),
        .rs1       (req_rs1),
        .rs2       (req_rs2),
        .imm       (req_imm),
        .word      (enc_word),
        .range_bad (range_bad)
    );

`ifdef RV_ENC_RANGE_CHECK_EN
    logic err_q;
    assign reject = range_bad;
    assign err    = err_q;
`else
    logic unused_range;
    assign unused_range = range_bad;
    assign reject       = 1'b0;
    assign err          = 1'b0;
`endif

    // The last word keeps its address in DONE, so the counter never wraps.
    assign last_word = &wr_addr[ADDR_WIDTH-1:2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            req_ready <= 1'b0;
            done      <= 1'b0;
`ifdef RV_ENC_RANGE_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_ACCEPT;
                        wr_addr   <= '0;
                        req_ready <= 1'b1;
                        done      <= 1'b0;
`ifdef RV_ENC_RANGE_CHECK_EN
                        err_q     <= 1'b0;
`endif
                    end
                end
                S_ACCEPT: begin
                    if (req_valid) begin
                        if (reject) begin
`ifdef RV_ENC_RANGE_CHECK_EN
                            err_q <= 1'b1;
`endif
                        end else begin
                            wr_data   <= DATA_WIDTH'(enc_word);
                            wr_en     <= 1'b1;
                            req_ready <= 1'b0;
                            state     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (wr_ready) begin
                        wr_en <= 1'b0;
                        if (last_word) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            wr_addr   <= wr_addr + ADDR_WIDTH'(4);
                            req_ready <= 1'b1;
                            state     <= S_ACCEPT;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
